// File: rtl/game_pkg.sv
// Shared game geometry, default kinematic constants and player state types.
// Imported by player_motion and by the bar and collision blocks so that all
// agree on screen and player dimensions.
package game_pkg;

    // Screen geometry (pixels)
    localparam int unsigned SCREEN_W    = 640;
    localparam int unsigned SCREEN_H    = 480;
    localparam int unsigned PLAYER_HALF = 20;

    // Datapath widths
    localparam int unsigned POS_W = 10;
    localparam int unsigned VEL_W = 8;

    // Default kinematic parameters
    localparam int unsigned H_START_DEF  = 120;
    localparam int unsigned H_END_DEF    = SCREEN_W - 2 * PLAYER_HALF;
    localparam int unsigned H_SPEED_DEF  = 2;
    localparam int unsigned V_START_DEF  = SCREEN_H / 2;
    localparam int unsigned V_MIN_DEF    = PLAYER_HALF;
    localparam int unsigned V_MAX_DEF    = SCREEN_H - PLAYER_HALF;
    localparam int unsigned GRAVITY_DEF  = 1;
    localparam int unsigned JUMP_VEL_DEF = 8;
    localparam int unsigned MAX_FALL_DEF = 10;

    typedef enum logic [1:0] {
        RESPAWN = 2'd0,
        READY   = 2'd1,
        FLY     = 2'd2
    } player_state_t;

    // Player centre position as seen by downstream consumers
    typedef struct packed {
        logic [POS_W-1:0] h;
        logic [POS_W-1:0] v;
    } player_pos_t;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a clk-synchronous level.
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   in       synchronous input level
//   pulse    combinational, high in the cycle where in is 1 and was 0 last cycle
module rise_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic in,
    output logic pulse
);

    logic in_q;

    // Previous-cycle copy of the input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in;
        end
    end

    // Left unregistered so an edge coinciding with a tick is seen by that tick
    assign pulse = in & ~in_q;

endmodule

// File: rtl/player_motion.sv
// Player kinematics: gravity, flap impulse and constant horizontal advance,
// evaluated once per frame tick. Detects floor strikes and lap wrap-around and
// honours respawn requests from the collision checker.
// Ports:
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   tick          one-cycle frame strobe
//   flap          debounced, clk-synchronous button level
//   reset_player  respawn request level (priority over tick/flap)
//   player_h      player centre x, registered
//   player_v      player centre y, registered
//   flying        high while in FLY
//   lap           one-cycle pulse on horizontal wrap
//   floor_hit     one-cycle pulse on floor strike
module player_motion
    import game_pkg::*;
#(
    parameter int unsigned H_START  = H_START_DEF,
    parameter int unsigned H_END    = H_END_DEF,
    parameter int unsigned H_SPEED  = H_SPEED_DEF,
    parameter int unsigned V_START  = V_START_DEF,
    parameter int unsigned V_MIN    = V_MIN_DEF,
    parameter int unsigned V_MAX    = V_MAX_DEF,
    parameter int unsigned GRAVITY  = GRAVITY_DEF,
    parameter int unsigned JUMP_VEL = JUMP_VEL_DEF,
    parameter int unsigned MAX_FALL = MAX_FALL_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             flap,
    input  logic             reset_player,
    output logic [POS_W-1:0] player_h,
    output logic [POS_W-1:0] player_v,
    output logic             flying,
    output logic             lap,
    output logic             floor_hit
);

    // One extra bit so position sums cannot wrap before comparison
    localparam int unsigned RAW_W = POS_W + 1;

    localparam logic [POS_W-1:0]        H_START_P = POS_W'(H_START);
    localparam logic [POS_W-1:0]        V_START_P = POS_W'(V_START);
    localparam logic [POS_W-1:0]        V_MIN_P   = POS_W'(V_MIN);
    localparam logic [POS_W-1:0]        V_MAX_P   = POS_W'(V_MAX);
    localparam logic [RAW_W-1:0]        H_END_R   = RAW_W'(H_END);
    localparam logic [RAW_W-1:0]        H_SPEED_R = RAW_W'(H_SPEED);
    localparam logic signed [RAW_W-1:0] V_MIN_S   = $signed(RAW_W'(V_MIN));
    localparam logic signed [RAW_W-1:0] V_MAX_S   = $signed(RAW_W'(V_MAX));
    localparam logic signed [VEL_W:0]   GRAV_S    = $signed((VEL_W+1)'(GRAVITY));
    localparam logic signed [VEL_W:0]   FALL_S    = $signed((VEL_W+1)'(MAX_FALL));
    localparam logic signed [VEL_W-1:0] JUMP_S    = -$signed(VEL_W'(JUMP_VEL));

    player_state_t           state_q, state_d;
    player_pos_t             pos_q, pos_d;
    logic signed [VEL_W-1:0] vel_q, vel_d;
    logic                    pend_q, pend_d;
    logic                    flying_q, flying_d;
    logic                    lap_q, lap_d;
    logic                    floor_q, floor_d;

    logic                    flap_edge;
    logic                    apply_flap;
    logic signed [VEL_W:0]   vel_sum;
    logic signed [VEL_W-1:0] vel_grav;
    logic signed [VEL_W-1:0] vel_next;
    logic signed [RAW_W-1:0] v_raw;
    logic [RAW_W-1:0]        h_raw;

    rise_detect u_flap_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .in      (flap),
        .pulse   (flap_edge)
    );

    // Candidate kinematics for a tick in FLY
    always_comb begin
        apply_flap = pend_q | flap_edge;
        vel_sum    = $signed({vel_q[VEL_W-1], vel_q}) + GRAV_S;
        vel_grav   = (vel_sum > FALL_S) ? VEL_W'(FALL_S) : VEL_W'(vel_sum);
        vel_next   = apply_flap ? JUMP_S : vel_grav;
        v_raw      = $signed({1'b0, pos_q.v}) + RAW_W'(vel_next);
        h_raw      = {1'b0, pos_q.h} + H_SPEED_R;
    end

    // Next-state and next-register logic
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        vel_d   = vel_q;
        pend_d  = pend_q;
        lap_d   = 1'b0;
        floor_d = 1'b0;

        if (reset_player) begin
            state_d = RESPAWN;
            pos_d.h = H_START_P;
            pos_d.v = V_START_P;
            vel_d   = '0;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                RESPAWN: begin
                    // Flap edges here are dropped, not remembered
                    state_d = READY;
                    pos_d.h = H_START_P;
                    pos_d.v = V_START_P;
                    vel_d   = '0;
                    pend_d  = 1'b0;
                end
                READY: begin
                    // First flap only arms the jump; movement starts at next tick
                    if (flap_edge) begin
                        state_d = FLY;
                        pend_d  = 1'b1;
                    end
                end
                FLY: begin
                    if (tick) begin
                        pend_d = 1'b0;

                        if (h_raw >= H_END_R) begin
                            pos_d.h = H_START_P;
                            lap_d   = 1'b1;
                        end else begin
                            pos_d.h = POS_W'(h_raw);
                        end

                        if (v_raw <= V_MIN_S) begin
                            pos_d.v = V_MIN_P;
                            vel_d   = '0;
                        end else if (v_raw >= V_MAX_S) begin
                            pos_d.v = V_MAX_P;
                            vel_d   = '0;
                            floor_d = 1'b1;
                            state_d = RESPAWN;
                        end else begin
                            pos_d.v = POS_W'(v_raw);
                            vel_d   = vel_next;
                        end
                    end else if (flap_edge) begin
                        pend_d = 1'b1;
                    end
                end
                default: begin
                    state_d = RESPAWN;
                end
            endcase
        end

        flying_d = (state_d == FLY);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= RESPAWN;
            pos_q.h  <= H_START_P;
            pos_q.v  <= V_START_P;
            vel_q    <= '0;
            pend_q   <= 1'b0;
            flying_q <= 1'b0;
            lap_q    <= 1'b0;
            floor_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            vel_q    <= vel_d;
            pend_q   <= pend_d;
            flying_q <= flying_d;
            lap_q    <= lap_d;
            floor_q  <= floor_d;
        end
    end

    assign player_h  = pos_q.h;
    assign player_v  = pos_q.v;
    assign flying    = flying_q;
    assign lap       = lap_q;
    assign floor_hit = floor_q;

endmodule

// File: tb/tb_player_motion.sv
// Directed bench for player_motion with hand-computed expected positions.
module tb_player_motion;

    logic       clk          = 1'b0;
    logic       reset_n      = 1'b1;
    logic       tick         = 1'b0;
    logic       flap         = 1'b0;
    logic       reset_player = 1'b1;
    logic [9:0] player_h;
    logic [9:0] player_v;
    logic       flying;
    logic       lap;
    logic       floor_hit;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    player_motion dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tick         (tick),
        .flap         (flap),
        .reset_player (reset_player),
        .player_h     (player_h),
        .player_v     (player_v),
        .flying       (flying),
        .lap          (lap),
        .floor_hit    (floor_hit)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic do_flap();
        flap = 1'b1;
        step();
        flap = 1'b0;
        step();
    endtask

    // Idle cycle with flap low, then a flap edge coinciding with a tick
    task automatic flap_tick();
        flap = 1'b0;
        step();
        flap = 1'b1;
        tick = 1'b1;
        step();
        flap = 1'b0;
        tick = 1'b0;
    endtask

    initial begin
        // Reset
        #2 reset_n = 1'b0;
        step();
        step();
        check("rst_h", player_h, 120);
        check("rst_v", player_v, 240);
        check("rst_flying", flying, 0);
        check("rst_lap", lap, 0);
        check("rst_floor", floor_hit, 0);
        reset_n = 1'b1;
        step();

        // Flap during RESPAWN must be forgotten
        do_flap();
        reset_player = 1'b0;
        step();
        do_tick();
        check("ready_h", player_h, 120);
        check("ready_v", player_v, 240);
        check("ready_flying", flying, 0);

        // READY -> FLY, no movement until tick
        do_flap();
        check("fly_flying", flying, 1);
        check("fly_hold_v", player_v, 240);
        do_tick();
        check("jump_v", player_v, 232);
        check("jump_h", player_h, 122);
        check("jump_flying", flying, 1);

        // Free fall from v=232, vel=-8 until the floor
        for (int i = 1; i <= 39; i++) begin
            do_tick();
            if (i == 8)  check("fall8_v", player_v, 204);
            if (i == 18) check("fall18_v", player_v, 259);
            if (i == 38) begin
                check("fall38_v", player_v, 459);
                check("fall38_floor", floor_hit, 0);
            end
        end
        check("floor_v", player_v, 460);
        check("floor_hit", floor_hit, 1);
        check("floor_flying", flying, 0);
        check("floor_h", player_h, 200);
        step();
        check("after_floor_h", player_h, 120);
        check("after_floor_v", player_v, 240);
        check("after_floor_pulse", floor_hit, 0);

        // Ceiling clamp: climb from 232 in steps of 8 to 24, then clamp to 20
        do_flap();
        do_tick();
        for (int i = 0; i < 26; i++) flap_tick();
        check("climb_v", player_v, 24);
        check("climb_h", player_h, 174);
        flap_tick();
        check("ceil_v", player_v, 20);
        check("ceil_h", player_h, 176);
        do_tick();
        check("ceil_next_v", player_v, 21);
        check("ceil_next_h", player_h, 178);

        // Respawn and fly to h=598, pinned at the ceiling
        reset_player = 1'b1;
        step();
        reset_player = 1'b0;
        step();
        do_flap();
        for (int i = 0; i < 239; i++) flap_tick();
        check("pre_rp_h", player_h, 598);
        check("pre_rp_v", player_v, 20);

        // reset_player wins over a tick that would have lapped
        reset_player = 1'b1;
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("rp_h", player_h, 120);
        check("rp_v", player_v, 240);
        check("rp_lap", lap, 0);
        check("rp_floor", floor_hit, 0);
        check("rp_flying", flying, 0);
        step();
        reset_player = 1'b0;
        step();

        // Lap wrap
        do_flap();
        for (int i = 0; i < 239; i++) flap_tick();
        check("pre_lap_h", player_h, 598);
        check("pre_lap_pulse", lap, 0);
        flap_tick();
        check("lap_h", player_h, 120);
        check("lap_pulse", lap, 1);
        step();
        check("lap_once", lap, 0);
        check("lap_hold_h", player_h, 120);

        // Asynchronous reset mid-flight
        do_tick();
        check("mid_h", player_h, 122);
        check("mid_v", player_v, 21);
        #2 reset_n = 1'b0;
        #1;
        check("async_h", player_h, 120);
        check("async_v", player_v, 240);
        check("async_flying", flying, 0);
        reset_n = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
